// File: rtl/sw_fasta_streamer.sv
// FASTA character parser feeding a Smith-Waterman systolic array, with result scoring and indexing.
// Best-hit tracking is built only when SW_BEST_TRACK_EN is defined.
module sw_fasta_streamer #(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 48,
    parameter int LOG_LENGTH  = 6,
    parameter int ID_WIDTH    = 16,
    parameter int ZERO        = 2**(SCORE_WIDTH-1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    input  logic [7:0]                    s_data,
    output logic                          s_ready,
    output logic [2*LENGTH-1:0]           query,
    output logic [LOG_LENGTH-1:0]         query_length,
    output logic                          query_vld,
    output logic                          en_out,
    output logic [1:0]                    data_out,
    output logic [11:0]                   counter_out,
    input  logic                          array_vld,
    input  logic [SCORE_WIDTH-1:0]        array_result,
    output logic                          res_valid,
    output logic signed [SCORE_WIDTH-1:0] res_score,
    output logic [ID_WIDTH-1:0]           res_id,
    output logic signed [SCORE_WIDTH-1:0] best_score,
    output logic [ID_WIDTH-1:0]           best_id,
    output logic                          q_trunc,
    output logic                          bad_char
);

    // IDLE: wait for '>' | Q_HDR/D_HDR: skip header line | Q_SEQ: load query bases
    // D_SEQ: stream bases to array | D_GAP: one-cycle flush between records
    typedef enum logic [2:0] {IDLE, Q_HDR, Q_SEQ, D_HDR, D_SEQ, D_GAP} state_t;

    localparam int QN_W = $clog2(LENGTH+1);
    localparam logic signed [SCORE_WIDTH-1:0] SCORE_MIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    state_t                          r_state;
    logic   [QN_W-1:0]               r_qn;
    logic   [11:0]                   r_dcnt;
    logic                            r_gap_eot;
    logic   [2*LENGTH-1:0]           r_query;
    logic   [LOG_LENGTH-1:0]         r_query_length;
    logic                            r_query_vld;
    logic                            r_en_out;
    logic   [1:0]                    r_data_out;
    logic   [11:0]                   r_counter_out;
    logic                            r_q_trunc;
    logic                            r_bad_char;
    logic                            r_res_valid;
    logic signed [SCORE_WIDTH-1:0]   r_res_score;
    logic   [ID_WIDTH-1:0]           r_res_id;
    logic   [ID_WIDTH-1:0]           r_rid;

    logic                            w_accept;
    logic                            w_is_base;
    logic   [1:0]                    w_base;
    logic                            w_lf;
    logic                            w_lf_cr;
    logic                            w_gt;
    logic                            w_eot;
    logic                            w_gap_eot;
    logic signed [SCORE_WIDTH-1:0]   w_score;

    assign s_ready   = rst && (r_state != D_GAP);
    assign w_accept  = s_valid && s_ready;
    assign w_lf      = (s_data == 8'h0A);
    assign w_lf_cr   = w_lf || (s_data == 8'h0D);
    assign w_gt      = (s_data == 8'h3E);
    assign w_eot     = (s_data == 8'h04);
    assign w_gap_eot = (r_state == D_GAP) && r_gap_eot;
    // Subtracting the biased zero is the same as flipping the MSB.
    assign w_score   = array_result - SCORE_WIDTH'(ZERO);

    always_comb begin
        w_is_base = 1'b1;
        w_base    = 2'b00;
        case (s_data)
            "A", "a": w_base = 2'b00;
            "G", "g": w_base = 2'b01;
            "T", "t": w_base = 2'b10;
            "C", "c": w_base = 2'b11;
            default:  w_is_base = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_qn           <= '0;
            r_dcnt         <= '0;
            r_gap_eot      <= 1'b0;
            r_query        <= '0;
            r_query_length <= '0;
            r_query_vld    <= 1'b0;
            r_en_out       <= 1'b0;
            r_data_out     <= 2'b00;
            r_counter_out  <= '0;
            r_q_trunc      <= 1'b0;
            r_bad_char     <= 1'b0;
        end else begin
            r_en_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && w_gt) r_state <= Q_HDR;
                end
                Q_HDR: begin
                    if (w_accept && w_lf) r_state <= Q_SEQ;
                end
                Q_SEQ: begin
                    if (w_accept) begin
                        if (w_is_base) begin
                            if (r_qn < QN_W'(LENGTH)) begin
                                r_query[{r_qn, 1'b0} +: 2] <= w_base;
                                r_qn                       <= r_qn + 1'b1;
                            end else begin
                                r_q_trunc <= 1'b1;
                            end
                        end else if (w_gt) begin
                            if (r_qn != '0) begin
                                r_query_vld    <= 1'b1;
                                r_query_length <= LOG_LENGTH'(r_qn - 1'b1);
                                r_state        <= D_HDR;
                            end
                        end else if (!w_lf_cr) begin
                            r_bad_char <= 1'b1;
                        end
                    end
                end
                D_HDR: begin
                    if (w_accept && w_lf) r_state <= D_SEQ;
                end
                D_SEQ: begin
                    if (w_accept) begin
                        if (w_is_base) begin
                            r_en_out      <= 1'b1;
                            r_data_out    <= w_base;
                            r_counter_out <= r_dcnt;
                            if (r_dcnt != 12'hFFF) r_dcnt <= r_dcnt + 12'd1;
                        end else if (w_gt) begin
                            // An empty record has nothing to flush, so skip the gap.
                            if (r_dcnt != '0) begin
                                r_gap_eot <= 1'b0;
                                r_state   <= D_GAP;
                            end else begin
                                r_state <= D_HDR;
                            end
                        end else if (w_eot) begin
                            r_gap_eot <= 1'b1;
                            r_state   <= D_GAP;
                        end else if (!w_lf_cr) begin
                            r_bad_char <= 1'b1;
                        end
                    end
                end
                D_GAP: begin
                    r_dcnt        <= '0;
                    r_counter_out <= '0;
                    if (r_gap_eot) begin
                        r_query_vld <= 1'b0;
                        r_qn        <= '0;
                        r_state     <= IDLE;
                    end else begin
                        r_state <= D_HDR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res_valid <= 1'b0;
            r_res_score <= '0;
            r_res_id    <= '0;
            r_rid       <= '0;
        end else begin
            r_res_valid <= array_vld;
            if (array_vld) begin
                r_res_score <= w_score;
                r_res_id    <= r_rid;
                r_rid       <= r_rid + 1'b1;
            end
            // A result arriving with the end-of-stream gap keeps its id; the clear lands after it.
            if (w_gap_eot) r_rid <= '0;
        end
    end

`ifdef SW_BEST_TRACK_EN
    logic signed [SCORE_WIDTH-1:0] r_best_score;
    logic        [ID_WIDTH-1:0]    r_best_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_best_score <= SCORE_MIN;
            r_best_id    <= '0;
        end else begin
            if (array_vld && (w_score > r_best_score)) begin
                r_best_score <= w_score;
                r_best_id    <= r_rid;
            end
            if (w_gap_eot) r_best_score <= SCORE_MIN;
        end
    end

    assign best_score = r_best_score;
    assign best_id    = r_best_id;
`else
    assign best_score = '0;
    assign best_id    = '0;
`endif

    assign query        = r_query;
    assign query_length = r_query_length;
    assign query_vld    = r_query_vld;
    assign en_out       = r_en_out;
    assign data_out     = r_data_out;
    assign counter_out  = r_counter_out;
    assign q_trunc      = r_q_trunc;
    assign bad_char     = r_bad_char;
    assign res_valid    = r_res_valid;
    assign res_score    = r_res_score;
    assign res_id       = r_res_id;

endmodule

// File: tb/tb_sw_fasta_streamer.sv
// Directed bench for sw_fasta_streamer: a character-level reference model checked every cycle,
// plus literal expectations for the documented example streams.
module tb_sw_fasta_streamer;
    localparam int SW  = 12;
    localparam int L   = 48;
    localparam int LL  = 6;
    localparam int IDW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid = 1'b0;
    logic [7:0]           s_data = 8'h00;
    logic                 s_ready;
    logic [2*L-1:0]       query;
    logic [LL-1:0]        query_length;
    logic                 query_vld;
    logic                 en_out;
    logic [1:0]           data_out;
    logic [11:0]          counter_out;
    logic                 array_vld = 1'b0;
    logic [SW-1:0]        array_result = '0;
    logic                 res_valid;
    logic signed [SW-1:0] res_score;
    logic [IDW-1:0]       res_id;
    logic signed [SW-1:0] best_score;
    logic [IDW-1:0]       best_id;
    logic                 q_trunc;
    logic                 bad_char;

    always #5 clk = ~clk;

    sw_fasta_streamer #(.SCORE_WIDTH(SW), .LENGTH(L), .LOG_LENGTH(LL), .ID_WIDTH(IDW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .query(query), .query_length(query_length), .query_vld(query_vld),
        .en_out(en_out), .data_out(data_out), .counter_out(counter_out),
        .array_vld(array_vld), .array_result(array_result),
        .res_valid(res_valid), .res_score(res_score), .res_id(res_id),
        .best_score(best_score), .best_id(best_id), .q_trunc(q_trunc), .bad_char(bad_char)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: parse mode, query contents, record position, result/best bookkeeping.
    localparam int M_IDLE = 0, M_QHDR = 1, M_QSEQ = 2, M_DHDR = 3, M_DSEQ = 4, M_GAP = 5;
    int       m_mode;
    bit       m_gap_eot;
    bit       m_ready;
    int       m_q [L];
    int       m_qn;
    bit       m_qvld;
    int       m_qlen;
    bit       m_trunc;
    bit       m_bad;
    int       m_bases;
    int       m_rid;
    int       m_best;
    int       m_best_id;
    bit       e_en;
    int       e_data;
    int       e_cnt;
    bit       e_rv;
    int       e_rs;
    int       e_rid;

    function automatic int base_code(input logic [7:0] c);
        case (c)
            "A", "a": return 0;
            "G", "g": return 1;
            "T", "t": return 2;
            "C", "c": return 3;
            default:  return -1;
        endcase
    endfunction

    function automatic logic [2*L-1:0] model_query();
        logic [2*L-1:0] q = '0;
        for (int k = 0; k < L; k++) q[2*k +: 2] = 2'(m_q[k]);
        return q;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_gap_eot = 0; m_ready = 1;
        for (int k = 0; k < L; k++) m_q[k] = 0;
        m_qn = 0; m_qvld = 0; m_qlen = 0; m_trunc = 0; m_bad = 0; m_bases = 0;
        m_rid = 0; m_best = -(2**(SW-1)); m_best_id = 0;
        e_en = 0; e_data = 0; e_cnt = 0; e_rv = 0; e_rs = 0; e_rid = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] c, input bit av, input logic [SW-1:0] ar);
        bit acc   = v && m_ready;
        int b     = base_code(c);
        bit clear = (m_mode == M_GAP) && m_gap_eot;
        e_en = 0;
        if (m_mode == M_GAP) begin
            m_bases = 0;
            if (m_gap_eot) begin m_qvld = 0; m_qn = 0; m_mode = M_IDLE; end
            else m_mode = M_DHDR;
        end else if (acc) begin
            case (m_mode)
                M_IDLE: if (c == 8'h3E) m_mode = M_QHDR;
                M_QHDR: if (c == 8'h0A) m_mode = M_QSEQ;
                M_DHDR: if (c == 8'h0A) m_mode = M_DSEQ;
                M_QSEQ: begin
                    if (b >= 0) begin
                        if (m_qn < L) begin m_q[m_qn] = b; m_qn++; end
                        else m_trunc = 1;
                    end else if (c == 8'h3E) begin
                        if (m_qn > 0) begin m_qvld = 1; m_qlen = m_qn - 1; m_mode = M_DHDR; end
                    end else if (c != 8'h0A && c != 8'h0D) m_bad = 1;
                end
                M_DSEQ: begin
                    if (b >= 0) begin
                        e_en = 1; e_data = b; e_cnt = (m_bases > 4095) ? 4095 : m_bases; m_bases++;
                    end else if (c == 8'h3E) begin
                        if (m_bases > 0) begin m_gap_eot = 0; m_mode = M_GAP; end
                        else m_mode = M_DHDR;
                    end else if (c == 8'h04) begin
                        m_gap_eot = 1; m_mode = M_GAP;
                    end else if (c != 8'h0A && c != 8'h0D) m_bad = 1;
                end
                default: ;
            endcase
        end
        e_rv = av;
        if (av) begin
            e_rs  = int'(ar) - 2**(SW-1);
            e_rid = m_rid;
            if (e_rs > m_best) begin m_best = e_rs; m_best_id = m_rid; end
            m_rid = (m_rid + 1) % (2**IDW);
        end
        if (clear) begin m_rid = 0; m_best = -(2**(SW-1)); end
        m_ready = (m_mode != M_GAP);
    endfunction

    bit          chk_on = 0;
    int          gap_cnt = 0;
    logic [13:0] en_log[$];
    int          rs_log[$];
    int          rid_log[$];

    always @(negedge clk) begin
        if (chk_on) begin
            chk("s_ready", s_ready, m_ready);
            if (!s_ready) gap_cnt++;
            chk("en_out", en_out, e_en);
            if (e_en) begin
                chk("data_out", data_out, e_data);
                chk("counter_out", counter_out, e_cnt);
            end
            if (en_out) en_log.push_back({data_out, counter_out});
            chk("query", query, model_query());
            chk("query_vld", query_vld, m_qvld);
            chk("query_length", query_length, m_qlen);
            chk("q_trunc", q_trunc, m_trunc);
            chk("bad_char", bad_char, m_bad);
            chk("res_valid", res_valid, e_rv);
            if (e_rv) begin
                chk("res_score", res_score, e_rs);
                chk("res_id", res_id, e_rid);
            end
            if (res_valid) begin rs_log.push_back(int'(res_score)); rid_log.push_back(int'(res_id)); end
`ifdef SW_BEST_TRACK_EN
            chk("best_score", best_score, m_best);
            chk("best_id", best_id, m_best_id);
`else
            chk("best_score", best_score, 0);
            chk("best_id", best_id, 0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(s_valid, s_data, array_vld, array_result);
    endtask

    task automatic send(input logic [7:0] c);
        int guard = 0;
        bit will_acc;
        s_valid = 1'b1;
        s_data  = c;
        forever begin
            will_acc = m_ready;
            tick();
            if (will_acc) break;
            guard++;
            if (guard > 8) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: char %0h not accepted", c);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic result(input logic [SW-1:0] ar);
        array_vld    = 1'b1;
        array_result = ar;
        tick();
        array_vld    = 1'b0;
    endtask

    initial begin
        string pat = "ACGT";
        int    base_n;
        model_reset();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_query", query, 0);
        chk("rst_query_vld", query_vld, 0);
        chk("rst_en_out", en_out, 0);
        chk("rst_counter_out", counter_out, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
`ifdef SW_BEST_TRACK_EN
        chk("rst_best_score", best_score, -2048);
`else
        chk("rst_best_score", best_score, 0);
`endif
        rst = 1'b1;
        model_reset();
        chk_on = 1;

        // Basic query + two-base database record
        send_str(">q\nACGT\n>d\nGA");
        idle(2);
        chk("ex1_query_lo", query[7:0], 8'h9C);
        chk("ex1_query_length", query_length, 3);
        chk("ex1_query_vld", query_vld, 1);
        chk("ex1_en_count", en_log.size(), 2);
        if (en_log.size() == 2) begin
            chk("ex1_en0", en_log[0], 14'h1000);
            chk("ex1_en1", en_log[1], 14'h0001);
        end
        send(8'h04);
        idle(3);

        // Two records then end-of-stream
        en_log.delete();
        gap_cnt = 0;
        send_str(">q\nA\n>d1\nAC\n>d2\nT");
        send(8'h04);
        idle(3);
        chk("ex2_gap_count", gap_cnt, 2);
        chk("ex2_query_vld", query_vld, 0);
        chk("ex2_en_count", en_log.size(), 3);
        if (en_log.size() == 3) begin
            chk("ex2_en0", en_log[0], 14'h0000);
            chk("ex2_en1", en_log[1], 14'h3001);
            chk("ex2_en2", en_log[2], 14'h2000);
        end
        send_str("ACGT");
        idle(1);
        chk("ex2_idle_no_en", en_log.size(), 3);

        // Result scoring, ids and best tracking
        result(12'h805);
        result(12'h7FC);
        result(12'h805);
        idle(1);
        chk("ex3_res_count", rs_log.size(), 3);
        if (rs_log.size() == 3) begin
            chk("ex3_s0", rs_log[0], 5);  chk("ex3_id0", rid_log[0], 0);
            chk("ex3_s1", rs_log[1], -4); chk("ex3_id1", rid_log[1], 1);
            chk("ex3_s2", rs_log[2], 5);  chk("ex3_id2", rid_log[2], 2);
        end
`ifdef SW_BEST_TRACK_EN
        chk("ex3_best_score", best_score, 5);
`else
        chk("ex3_best_score", best_score, 0);
`endif
        chk("ex3_best_id", best_id, 0);

        // Result landing in the end-of-stream gap keeps its id, then the counter clears
        send_str(">q\nA\n>d\nG");
        send(8'h04);
        result(12'h810);
        idle(1);
        result(12'h801);
        idle(1);
        chk("ex4_res_count", rs_log.size(), 5);
        if (rs_log.size() == 5) begin
            chk("ex4_s3", rs_log[3], 16); chk("ex4_id3", rid_log[3], 3);
            chk("ex4_s4", rs_log[4], 1);  chk("ex4_id4", rid_log[4], 0);
        end
`ifdef SW_BEST_TRACK_EN
        chk("ex4_best_score", best_score, 1);
`endif

        // Over-long query and a bad character in a record
        chk("ex5_trunc_before", q_trunc, 0);
        chk("ex5_bad_before", bad_char, 0);
        send_str(">q\n");
        for (int i = 0; i < L + 3; i++) send(pat[i % 4]);
        send_str(">d\n");
        en_log.delete();
        send_str("AXG\n\r>d\n");
        idle(1);
        chk("ex5_query_length", query_length, L - 1);
        chk("ex5_q_trunc", q_trunc, 1);
        chk("ex5_en_count", en_log.size(), 2);
        chk("ex5_bad_char", bad_char, 1);

        // Position counter saturation
        en_log.delete();
        base_n = 4100;
        for (int i = 0; i < base_n; i++) send("T");
        send(">");
        idle(2);
        chk("sat_en_count", en_log.size(), base_n);
        if (en_log.size() == base_n) begin
            chk("sat_4094", en_log[4094][11:0], 4094);
            chk("sat_4095", en_log[4095][11:0], 4095);
            chk("sat_last", en_log[base_n-1][11:0], 4095);
        end

        // Reset in the middle of a record
        send_str("d\nAC");
        chk_on = 0;
        rst = 1'b0;
        #1;
        chk("mid_rst_en_out", en_out, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_query_vld", query_vld, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        chk_on = 1;
        send_str(">q\nA\n>");
        idle(1);
        chk("post_rst_query_vld", query_vld, 1);
        chk("post_rst_query_length", query_length, 0);
        chk("post_rst_query", query, 0);
        rs_log.delete();
        rid_log.delete();
        result(12'h803);
        idle(1);
        chk("post_rst_res_count", rid_log.size(), 1);
        if (rid_log.size() == 1) begin
            chk("post_rst_res_id", rid_log[0], 0);
            chk("post_rst_res_score", rs_log[0], 3);
        end

        idle(2);
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
